// File: rtl/hilo_mul_unit.sv
// HI/LO multiply-accumulate unit: fixed-latency pipeline that owns the architectural
// HI/LO pair and provides interlocked MFHI/MFLO reads.
module hilo_mul_unit #(
    parameter int XLEN        = 32,
    parameter int MUL_STAGES  = 3,
    parameter int ENABLE_MSUB = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            op_ready,
    input  logic            flush,
    input  logic            rd_req,
    input  logic            rd_sel,
    output logic            rd_valid,
    output logic [XLEN-1:0] rd_data,
    output logic            busy,
    output logic            commit_valid,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int PW   = 2 * XLEN;
    localparam int LAST = MUL_STAGES - 1;

    typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_e;

    function automatic logic [PW-1:0] extend(input logic [XLEN-1:0] v, input logic sgn);
        return sgn ? {{XLEN{v[XLEN-1]}}, v} : {{XLEN{1'b0}}, v};
    endfunction

    function automatic logic [PW-1:0] accumulate(input acc_e mode, input logic [PW-1:0] base,
                                                 input logic [PW-1:0] prod);
        case (mode)
            ACC_ADD: return base + prod;
            ACC_SUB: return base - prod;
            default: return prod;
        endcase
    endfunction

    logic            vld_p   [MUL_STAGES];
    logic            wr_hi_p [MUL_STAGES];
    logic            wr_lo_p [MUL_STAGES];
    acc_e            acc_p   [MUL_STAGES];
    logic [PW-1:0]   prod_p  [MUL_STAGES];

    logic            is_move;
    logic            msub_off;
    logic [PW-1:0]   issue_prod;
    acc_e            issue_acc;
    logic            issue_wr_hi;
    logic            issue_wr_lo;
    logic            do_commit;
    logic [PW-1:0]   result;

    assign op_ready = !rst && !flush;
    assign rd_valid = rd_req && !busy && !rst;
    assign rd_data  = rd_sel ? lo : hi;

    // MTHI/MTLO carry their data duplicated in both halves so the final stage can
    // treat every op as "write selected halves of a 2*XLEN result".
    always_comb begin
        is_move     = op[2] & op[1];
        msub_off    = (op[2:1] == 2'b10) && (ENABLE_MSUB == 0);
        issue_prod  = is_move ? {op_a, op_a}
                              : extend(op_a, !op[0]) * extend(op_b, !op[0]);
        issue_acc   = (op[2:1] == 2'b01) ? ACC_ADD :
                      (op[2:1] == 2'b10) ? ACC_SUB : ACC_NONE;
        issue_wr_hi = is_move ? !op[0] : !msub_off;
        issue_wr_lo = is_move ?  op[0] : !msub_off;
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < MUL_STAGES; i++) busy = busy | vld_p[i];
    end

    // Final stage: accumulate against the live HI/LO so back-to-back ops chain.
    assign result    = accumulate(acc_p[LAST], {hi, lo}, prod_p[LAST]);
    assign do_commit = vld_p[LAST] && !flush && (wr_hi_p[LAST] || wr_lo_p[LAST]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MUL_STAGES; i++) vld_p[i] <= 1'b0;
            commit_valid <= 1'b0;
            hi           <= '0;
            lo           <= '0;
        end else begin
            vld_p[0] <= op_valid && op_ready;
            for (int i = 1; i < MUL_STAGES; i++) vld_p[i] <= vld_p[i-1] && !flush;
            commit_valid <= do_commit;
            if (do_commit && wr_hi_p[LAST]) hi <= result[PW-1:XLEN];
            if (do_commit && wr_lo_p[LAST]) lo <= result[XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        prod_p[0]  <= issue_prod;
        acc_p[0]   <= issue_acc;
        wr_hi_p[0] <= issue_wr_hi;
        wr_lo_p[0] <= issue_wr_lo;
        for (int i = 1; i < MUL_STAGES; i++) begin
            prod_p[i]  <= prod_p[i-1];
            acc_p[i]   <= acc_p[i-1];
            wr_hi_p[i] <= wr_hi_p[i-1];
            wr_lo_p[i] <= wr_lo_p[i-1];
        end
    end
endmodule

// File: tb/tb_hilo_mul_unit.sv
// Bench for hilo_mul_unit: directed scenarios plus random traffic against a
// queue-based reference model of HI/LO, run on MSUB-enabled and MSUB-disabled instances.
module tb_hilo_mul_unit;
    localparam int STAGES = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] op_a, op_b;
    logic        flush, rd_req, rd_sel;
    logic        op_ready, rd_valid, busy, commit_valid;
    logic [31:0] rd_data, hi, lo;
    logic        n_op_ready, n_rd_valid, n_busy, n_commit_valid;
    logic [31:0] n_rd_data, n_hi, n_lo;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          due;
    } pend_t;

    pend_t       q[$];
    logic [63:0] m_acc = '0;
    logic [63:0] n_acc = '0;
    int          cyc = 0;

    always #5 clk = ~clk;

    hilo_mul_unit #(.XLEN(32), .MUL_STAGES(STAGES), .ENABLE_MSUB(1)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_a(op_a), .op_b(op_b),
        .op_ready(op_ready), .flush(flush), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
        .commit_valid(commit_valid), .hi(hi), .lo(lo));

    hilo_mul_unit #(.XLEN(32), .MUL_STAGES(STAGES), .ENABLE_MSUB(0)) dut_nm (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_a(op_a), .op_b(op_b),
        .op_ready(n_op_ready), .flush(flush), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_valid(n_rd_valid), .rd_data(n_rd_data), .busy(n_busy),
        .commit_valid(n_commit_valid), .hi(n_hi), .lo(n_lo));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic on a 64-bit {HI,LO} value.
    function automatic logic [63:0] apply(input pend_t e, input logic [63:0] cur,
                                          input bit en, output bit wrote);
        longint p;
        wrote = 1'b1;
        if (e.op[0]) p = longint'({32'b0, e.a}) * longint'({32'b0, e.b});
        else         p = longint'($signed(e.a)) * longint'($signed(e.b));
        case (e.op)
            3'd0, 3'd1: return p;
            3'd2, 3'd3: return cur + p;
            3'd4, 3'd5: begin
                if (en) return cur - p;
                wrote = 1'b0;
                return cur;
            end
            3'd6:    return {e.a, cur[31:0]};
            default: return {cur[63:32], e.a};
        endcase
    endfunction

    task automatic tick();
        bit    exp_busy, accepted, w, cv_m, cv_n;
        pend_t e;
        #2;
        exp_busy = (q.size() != 0);
        check("op_ready", op_ready, !rst && !flush);
        check("rd_valid", rd_valid, rd_req && !exp_busy && !rst);
        check("nm_rd_valid", n_rd_valid, rd_req && !exp_busy && !rst);
        if (rd_req && !exp_busy && !rst) begin
            check("rd_data", rd_data, rd_sel ? m_acc[31:0] : m_acc[63:32]);
            check("nm_rd_data", n_rd_data, rd_sel ? n_acc[31:0] : n_acc[63:32]);
        end
        accepted = op_valid && !rst && !flush;
        @(posedge clk);
        cyc++;
        cv_m = 1'b0;
        cv_n = 1'b0;
        if (flush) q.delete();
        else if (q.size() > 0 && q[0].due == cyc) begin
            e     = q.pop_front();
            m_acc = apply(e, m_acc, 1'b1, w);
            cv_m  = w;
            n_acc = apply(e, n_acc, 1'b0, w);
            cv_n  = w;
        end
        if (accepted) q.push_back('{op: op, a: op_a, b: op_b, due: cyc + STAGES});
        #1;
        check("hi", hi, m_acc[63:32]);
        check("lo", lo, m_acc[31:0]);
        check("commit_valid", commit_valid, cv_m);
        check("busy", busy, q.size() != 0);
        check("nm_hi", n_hi, n_acc[63:32]);
        check("nm_lo", n_lo, n_acc[31:0]);
        check("nm_commit_valid", n_commit_valid, cv_n);
        check("nm_busy", n_busy, q.size() != 0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op = o;
        op_a = a;
        op_b = b;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] save_hi, save_lo;
        rst = 1'b1; op_valid = 1'b0; op = '0; op_a = '0; op_b = '0;
        flush = 1'b0; rd_req = 1'b1; rd_sel = 1'b0;
        #3;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_commit", commit_valid, 0);
        check("rst_op_ready", op_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_req = 1'b0;

        // MULT / MULTU sign handling
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        idle(STAGES);
        check("t1_mult_hi", hi, 32'hFFFF_FFFF);
        check("t1_mult_lo", lo, 32'hFFFF_FFFA);
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        idle(STAGES);
        check("t1_multu_hi", hi, 32'h0000_0002);
        check("t1_multu_lo", lo, 32'hFFFF_FFFA);

        // MTHI, MTLO, MADDU chained on consecutive cycles
        issue(3'd6, 32'h0, 32'h0);
        issue(3'd7, 32'd5, 32'h0);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(STAGES);
        check("t2_hi", hi, 32'hFFFF_FFFE);
        check("t2_lo", lo, 32'h0000_0006);

        // MSUB from zero, with and without MSUB support
        issue(3'd0, 32'h0, 32'h0);
        idle(STAGES);
        issue(3'd4, 32'd1, 32'd1);
        idle(STAGES);
        check("t3_hi", hi, 32'hFFFF_FFFF);
        check("t3_lo", lo, 32'hFFFF_FFFF);
        check("t3_nm_hi", n_hi, 32'h0);
        check("t3_nm_lo", n_lo, 32'h0);

        // MFLO interlocked behind a MULT
        issue(3'd0, 32'd7, 32'd6);
        rd_req = 1'b1;
        rd_sel = 1'b1;
        idle(STAGES);
        #1;
        check("t4_rd_valid", rd_valid, 1);
        check("t4_rd_data", rd_data, 32'h0000_002A);
        rd_req = 1'b0;

        // Flush with two MULTs in flight and a new op offered during the flush
        save_hi = hi;
        save_lo = lo;
        issue(3'd0, 32'd3, 32'd3);
        issue(3'd0, 32'd4, 32'd4);
        flush = 1'b1;
        op_valid = 1'b1;
        op = 3'd0; op_a = 32'd9; op_b = 32'd9;
        tick();
        flush = 1'b0;
        op_valid = 1'b0;
        check("t5_busy", busy, 0);
        idle(STAGES + 1);
        check("t5_hi", hi, save_hi);
        check("t5_lo", lo, save_lo);

        // Asynchronous reset in the middle of a MADDU
        issue(3'd3, 32'd10, 32'd10);
        idle(1);
        rst = 1'b1;
        rd_req = 1'b1;
        #2;
        q.delete();
        m_acc = '0;
        n_acc = '0;
        check("t6_hi", hi, 0);
        check("t6_lo", lo, 0);
        check("t6_busy", busy, 0);
        check("t6_op_ready", op_ready, 0);
        check("t6_rd_valid", rd_valid, 0);
        rst = 1'b0;
        rd_req = 1'b0;
        idle(STAGES + 1);
        issue(3'd0, 32'd2, 32'd2);
        idle(STAGES);
        check("t6_lo_after", lo, 32'd4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            op_valid = ($urandom_range(0, 9) < 7);
            op       = 3'($urandom_range(0, 7));
            op_a     = rnd_word();
            op_b     = rnd_word();
            flush    = ($urandom_range(0, 19) == 0);
            rd_req   = $urandom_range(0, 1) == 1;
            rd_sel   = $urandom_range(0, 1) == 1;
            tick();
        end
        op_valid = 1'b0;
        flush = 1'b0;
        rd_req = 1'b0;
        idle(STAGES + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
